// File: rtl/gpio_bank_pkg.sv
// Shared constants, register selectors and sizing helpers for the GPIO register bank.
package gpio_bank_pkg;

  localparam int unsigned IO_BASE   = 32'h0000_1000;
  localparam int unsigned DDR_BASE  = 32'h0000_1100;
  localparam int unsigned OD_BASE   = 32'h0000_1300;
  localparam int unsigned RISE_BASE = 32'h0000_1400;
  localparam int unsigned FALL_BASE = 32'h0000_1500;
  localparam int unsigned STAT_BASE = 32'h0000_1600;
  localparam int unsigned FILT_ADDR = 32'h0000_1800;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_IO,
    SEL_DDR,
    SEL_OD,
    SEL_RISE,
    SEL_FALL,
    SEL_STAT,
    SEL_FILT
  } reg_sel_e;

  function automatic int unsigned num_words(input int unsigned npins, input int unsigned regw);
    return (npins + regw - 1) / regw;
  endfunction

  // True when a byte address falls inside a bank of nwords consecutive 32-bit words.
  function automatic logic in_bank(input int unsigned addr, input int unsigned base,
                                   input int unsigned nwords);
    return (addr >= base) && (addr < base + 4 * nwords);
  endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// One pin's two-flop synchroniser followed by a stability-count glitch filter.
module gpio_in_filter #(
  parameter int unsigned FiltWidth = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pad,
  input  logic [FiltWidth-1:0] i_len,
  output logic                 o_filt
);

  logic                 r_s1;
  logic                 r_s2;
  logic                 r_filt;
  logic [FiltWidth-1:0] r_cnt;

  // A change is accepted once the synced level has differed for i_len+1 samples.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i_pad;
      r_s2 <= r_s1;
      if (r_s2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt >= i_len) begin
        r_filt <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + FiltWidth'(1);
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/gpio_bank_ctrl.sv
// Parametrised GPIO register bank: data/DDR/OD registers, filtered inputs,
// edge capture with W1C status and a single level interrupt.
module gpio_bank_ctrl
  import gpio_bank_pkg::*;
#(
  parameter int unsigned NumGPIO    = 2,
  parameter int unsigned GPIOWidth  = 36,
  parameter int unsigned IoRegWidth = 24,
  parameter int unsigned FiltWidth  = 8,
  parameter int unsigned AddrWidth  = 16,
  parameter int unsigned BusWidth   = 32
) (
  input  logic                           reg_clk,
  input  logic                           reset_in,
  input  logic                           chip_sel,
  input  logic                           write_reg,
  input  logic                           read_reg,
  input  logic [AddrWidth-1:2]           busaddress,
  input  logic [BusWidth-1:0]            busdata_in,
  input  logic [BusWidth-1:0]            busdata_fromhm2,
  output logic [BusWidth-1:0]            busdata_to_cpu,
  output logic                           read_valid,
  input  logic [NumGPIO*GPIOWidth-1:0]   pad_in,
  output logic [NumGPIO*GPIOWidth-1:0]   pad_out,
  output logic [NumGPIO*GPIOWidth-1:0]   pad_oe,
  output logic                           irq
);

  localparam int unsigned NPins    = NumGPIO * GPIOWidth;
  localparam int unsigned NumWords = num_words(NPins, IoRegWidth);
  localparam int unsigned IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;

  typedef logic [IoRegWidth-1:0] word_t;

  logic                 r_wr, r_rd, r_rd_p, r_rvalid, r_irq;
  logic [AddrWidth-1:2] r_addr;
  logic [BusWidth-1:0]  r_wdata, r_hm2, r_rdata, r_busdata;
  logic [FiltWidth-1:0] r_len;
  logic [NPins-1:0]     r_pad_out, r_pad_oe;
  word_t                r_data [NumWords];
  word_t                r_ddr  [NumWords];
  word_t                r_od   [NumWords];
  word_t                r_rise [NumWords];
  word_t                r_fall [NumWords];
  word_t                r_stat [NumWords];
  word_t                r_filt_d [NumWords];

  logic [NPins-1:0]     w_filt, w_dout, w_pad_out, w_pad_oe;
  word_t                w_filt_w [NumWords];
  word_t                w_mask   [NumWords];
  word_t                w_set    [NumWords];
  word_t                w_clr    [NumWords];
  word_t                w_wword, w_word;
  logic [BusWidth-1:0]  w_rdata;
  logic [IdxW-1:0]      w_idx;
  reg_sel_e             w_sel;
  int unsigned          w_a, w_off;
  logic                 w_any;
  logic                 w_unused;

  assign w_wword  = r_wdata[IoRegWidth-1:0];
  assign w_unused = ^r_wdata[BusWidth-1:IoRegWidth];

  // Bus strobes and payload captured one cycle ahead of decode.
  always_ff @(posedge reg_clk) begin
    if (reset_in) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hm2   <= '0;
    end else begin
      r_wr    <= chip_sel & write_reg;
      r_rd    <= chip_sel & read_reg;
      r_addr  <= busaddress;
      r_wdata <= busdata_in;
      r_hm2   <= busdata_fromhm2;
    end
  end

  always_comb begin
    w_a   = 32'({r_addr, 2'b00});
    w_sel = SEL_NONE;
    w_off = 0;
    if (in_bank(w_a, IO_BASE, NumWords)) begin
      w_sel = SEL_IO;   w_off = w_a - IO_BASE;
    end else if (in_bank(w_a, DDR_BASE, NumWords)) begin
      w_sel = SEL_DDR;  w_off = w_a - DDR_BASE;
    end else if (in_bank(w_a, OD_BASE, NumWords)) begin
      w_sel = SEL_OD;   w_off = w_a - OD_BASE;
    end else if (in_bank(w_a, RISE_BASE, NumWords)) begin
      w_sel = SEL_RISE; w_off = w_a - RISE_BASE;
    end else if (in_bank(w_a, FALL_BASE, NumWords)) begin
      w_sel = SEL_FALL; w_off = w_a - FALL_BASE;
    end else if (in_bank(w_a, STAT_BASE, NumWords)) begin
      w_sel = SEL_STAT; w_off = w_a - STAT_BASE;
    end else if (w_a == FILT_ADDR) begin
      w_sel = SEL_FILT;
    end
    w_idx = IdxW'(w_off >> 2);
  end

  always_comb begin
    w_word = '0;
    for (int k = 0; k < NumWords; k++) begin
      if (w_idx == IdxW'(k)) begin
        case (w_sel)
          SEL_IO:   w_word = w_filt_w[k];
          SEL_DDR:  w_word = r_ddr[k];
          SEL_OD:   w_word = r_od[k];
          SEL_RISE: w_word = r_rise[k];
          SEL_FALL: w_word = r_fall[k];
          SEL_STAT: w_word = r_stat[k];
          default:  w_word = '0;
        endcase
      end
    end
    case (w_sel)
      SEL_NONE: w_rdata = r_hm2;
      SEL_FILT: w_rdata = BusWidth'(r_len);
      default:  w_rdata = BusWidth'(w_word);
    endcase
  end

  // Register file writes; pad bits beyond NPins are masked off.
  always_ff @(posedge reg_clk) begin
    if (reset_in) begin
      r_len <= '0;
      for (int k = 0; k < NumWords; k++) begin
        r_data[k] <= '0;
        r_ddr[k]  <= '0;
        r_od[k]   <= '0;
        r_rise[k] <= '0;
        r_fall[k] <= '0;
      end
    end else if (r_wr) begin
      if (w_sel == SEL_FILT) r_len <= r_wdata[FiltWidth-1:0];
      for (int k = 0; k < NumWords; k++) begin
        if (w_idx == IdxW'(k)) begin
          case (w_sel)
            SEL_IO:   r_data[k] <= w_wword & w_mask[k];
            SEL_DDR:  r_ddr[k]  <= w_wword & w_mask[k];
            SEL_OD:   r_od[k]   <= w_wword & w_mask[k];
            SEL_RISE: r_rise[k] <= w_wword & w_mask[k];
            SEL_FALL: r_fall[k] <= w_wword & w_mask[k];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    w_any = 1'b0;
    for (int k = 0; k < NumWords; k++) begin
      w_set[k] = (w_filt_w[k] & ~r_filt_d[k] & r_rise[k]) |
                 (~w_filt_w[k] & r_filt_d[k] & r_fall[k]);
      w_clr[k] = (r_wr && (w_sel == SEL_STAT) && (w_idx == IdxW'(k))) ? w_wword : '0;
      w_any    = w_any | (|r_stat[k]);
    end
  end

  // Edge capture: a same-cycle set wins over a W1C of that bit.
  always_ff @(posedge reg_clk) begin
    if (reset_in) begin
      r_irq <= 1'b0;
      for (int k = 0; k < NumWords; k++) begin
        r_stat[k]   <= '0;
        r_filt_d[k] <= '0;
      end
    end else begin
      r_irq <= w_any;
      for (int k = 0; k < NumWords; k++) begin
        r_stat[k]   <= (r_stat[k] & ~w_clr[k]) | w_set[k];
        r_filt_d[k] <= w_filt_w[k];
      end
    end
  end

  for (genvar p = 0; p < NPins; p++) begin : g_pin
    gpio_in_filter #(.FiltWidth(FiltWidth)) u_filt (
      .i_clk  (reg_clk),
      .i_rst  (reset_in),
      .i_pad  (pad_in[p]),
      .i_len  (r_len),
      .o_filt (w_filt[p])
    );
    assign w_dout[p]    = r_data[p / IoRegWidth][p % IoRegWidth];
    assign w_pad_oe[p]  = r_od[p / IoRegWidth][p % IoRegWidth] ? ~w_dout[p]
                                                               : r_ddr[p / IoRegWidth][p % IoRegWidth];
    assign w_pad_out[p] = ~r_od[p / IoRegWidth][p % IoRegWidth] & w_dout[p];
  end

  for (genvar k = 0; k < NumWords; k++) begin : g_word
    for (genvar b = 0; b < IoRegWidth; b++) begin : g_bit
      if (k * IoRegWidth + b < NPins) begin : g_live
        assign w_filt_w[k][b] = w_filt[k * IoRegWidth + b];
        assign w_mask[k][b]   = 1'b1;
      end else begin : g_pad
        assign w_filt_w[k][b] = 1'b0;
        assign w_mask[k][b]   = 1'b0;
      end
    end
  end

  // Read data sampled one cycle after the strobe, presented the cycle after.
  always_ff @(posedge reg_clk) begin
    if (reset_in) begin
      r_rd_p    <= 1'b0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_busdata <= '0;
      r_pad_out <= '0;
      r_pad_oe  <= '0;
    end else begin
      r_rd_p    <= r_rd;
      r_rvalid  <= r_rd_p;
      r_pad_out <= w_pad_out;
      r_pad_oe  <= w_pad_oe;
      if (r_rd)   r_rdata   <= w_rdata;
      if (r_rd_p) r_busdata <= r_rdata;
    end
  end

  assign busdata_to_cpu = r_busdata;
  assign read_valid     = r_rvalid;
  assign irq            = r_irq;
  assign pad_out        = r_pad_out;
  assign pad_oe         = r_pad_oe;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed scoreboard bench for gpio_bank_ctrl built with three connectors (108 pins).
module tb_gpio_bank_ctrl;

  localparam int unsigned NumGPIO   = 3;
  localparam int unsigned GPIOWidth = 36;
  localparam int unsigned NPins     = NumGPIO * GPIOWidth;

  logic              reg_clk = 1'b0;
  logic              reset_in = 1'b1;
  logic              chip_sel = 1'b0;
  logic              write_reg = 1'b0;
  logic              read_reg = 1'b0;
  logic [15:2]       busaddress = '0;
  logic [31:0]       busdata_in = '0;
  logic [31:0]       busdata_fromhm2 = 32'hCAFE_F00D;
  logic [31:0]       busdata_to_cpu;
  logic              read_valid;
  logic [NPins-1:0]  pad_in = '0;
  logic [NPins-1:0]  pad_out;
  logic [NPins-1:0]  pad_oe;
  logic              irq;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];

  gpio_bank_ctrl #(.NumGPIO(NumGPIO), .GPIOWidth(GPIOWidth)) dut (
    .reg_clk         (reg_clk),
    .reset_in        (reset_in),
    .chip_sel        (chip_sel),
    .write_reg       (write_reg),
    .read_reg        (read_reg),
    .busaddress      (busaddress),
    .busdata_in      (busdata_in),
    .busdata_fromhm2 (busdata_fromhm2),
    .busdata_to_cpu  (busdata_to_cpu),
    .read_valid      (read_valid),
    .pad_in          (pad_in),
    .pad_out         (pad_out),
    .pad_oe          (pad_oe),
    .irq             (irq)
  );

  always #5 reg_clk = ~reg_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Monitor: every read_valid pops one expected word.
  always @(negedge reg_clk) begin
    if (read_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_read_valid: got data %h required no read_valid", busdata_to_cpu);
      end else begin
        chk(name_q.pop_front(), 128'(busdata_to_cpu), 128'(exp_q.pop_front()));
      end
    end
  end

  task automatic bus_op(input logic rd, input logic wr, input logic [15:0] addr, input logic [31:0] wd);
    chip_sel   = 1'b1;
    read_reg   = rd;
    write_reg  = wr;
    busaddress = addr[15:2];
    busdata_in = wd;
    @(negedge reg_clk);
    chip_sel  = 1'b0;
    read_reg  = 1'b0;
    write_reg = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] wd);
    bus_op(1'b0, 1'b1, addr, wd);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    bus_op(1'b1, 1'b0, addr, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge reg_clk);
  endtask

  task automatic drain();
    int budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge reg_clk);
      budget--;
    end
    while (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL %s: got no read_valid required %h", name_q.pop_front(), exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    idle(3);
    reset_in = 1'b0;
    chk("reset_pad_oe", 128'(pad_oe), 128'h0);
    chk("reset_pad_out", 128'(pad_out), 128'h0);
    chk("reset_irq", 128'(irq), 128'h0);
    chk("reset_read_valid", 128'(read_valid), 128'h0);

    rd(16'h1000, 32'h0, "rd_io0_reset");
    rd(16'h1100, 32'h0, "rd_ddr0_reset");
    rd(16'h1300, 32'h0, "rd_od0_reset");
    rd(16'h0300, 32'hCAFE_F00D, "rd_fallthrough");
    drain();

    // Data/direction on pins 24..35 with write-to-pad latency.
    wr(16'h1104, 32'h0000_0FFF);
    idle(2);
    chk("ddr_pad_oe", 128'(pad_oe), 128'(12'hFFF) << 24);
    wr(16'h1004, 32'h0000_0A5A);
    @(negedge reg_clk);
    chk("io_pad_out_edge1", 128'(pad_out), 128'h0);
    @(negedge reg_clk);
    chk("io_pad_out_edge2", 128'(pad_out), 128'(12'hA5A) << 24);

    // Open-drain on pins 24 (data 0) and 25 (data 1).
    wr(16'h1304, 32'h0000_0003);
    idle(2);
    chk("od_pad_oe", 128'(pad_oe), 128'(12'hFFD) << 24);
    chk("od_pad_out", 128'(pad_out), 128'(12'hA58) << 24);
    wr(16'h1104, 32'h0);
    idle(2);
    chk("od_ignores_ddr", 128'(pad_oe), 128'h1 << 24);
    rd(16'h1304, 32'h3, "rd_od1");
    rd(16'h1104, 32'h0, "rd_ddr1");
    rd(16'h1004, 32'h0, "rd_io1_filtered");
    drain();

    // Glitch filter with L=4.
    wr(16'h1800, 32'h4);
    idle(2);
    rd(16'h1800, 32'h4, "rd_filt_len");
    pad_in[3] = 1'b1;
    idle(4);
    pad_in[3] = 1'b0;
    idle(10);
    rd(16'h1000, 32'h0, "filt_pulse4_rejected");
    pad_in[3] = 1'b1;
    idle(12);
    rd(16'h1000, 32'h8, "filt_hold5_accepted");
    drain();
    wr(16'h1800, 32'h0);
    idle(2);

    // Rise edge on pin 0 with L=0: irq on the fifth edge.
    wr(16'h1400, 32'h1);
    idle(2);
    pad_in[0] = 1'b1;
    idle(4);
    chk("irq_before_5", 128'(irq), 128'h0);
    idle(1);
    chk("irq_at_5", 128'(irq), 128'h1);
    rd(16'h1600, 32'h1, "stat_rise");
    drain();
    wr(16'h1600, 32'h1);
    idle(2);
    chk("irq_after_w1c", 128'(irq), 128'h0);
    rd(16'h1600, 32'h0, "stat_cleared");
    drain();

    // Fall edge, then a rise whose status set lands on the W1C commit edge.
    wr(16'h1500, 32'h1);
    idle(2);
    pad_in[0] = 1'b0;
    idle(6);
    chk("irq_fall", 128'(irq), 128'h1);
    pad_in[0] = 1'b1;
    idle(2);
    wr(16'h1600, 32'h1);
    idle(3);
    rd(16'h1600, 32'h1, "stat_set_beats_clear");
    drain();
    chk("irq_set_beats_clear", 128'(irq), 128'h1);

    // Word 4 holds pins 96..107 only; bits above read zero.
    pad_in[107:96] = 12'hFFF;
    idle(5);
    rd(16'h1010, 32'h0000_0FFF, "rd_io4_partial");
    rd(16'h1000, 32'h0000_0009, "rd_io0_pins0_3");
    wr(16'h1108, 32'hFFFF_FFFF);
    wr(16'h1110, 32'hFFFF_FFFF);
    idle(2);
    rd(16'h1108, 32'h00FF_FFFF, "rd_ddr2_masked");
    rd(16'h1110, 32'h0000_0FFF, "rd_ddr4_masked");
    drain();

    // Same-cycle read and write returns pre-write data.
    exp_q.push_back(32'h1);
    name_q.push_back("rw_same_cycle_old");
    bus_op(1'b1, 1'b1, 16'h1400, 32'h5);
    rd(16'h1400, 32'h5, "rw_same_cycle_new");
    drain();
    idle(3);

    // Reset one cycle after a read strobe.
    bus_op(1'b1, 1'b0, 16'h1000, 32'h0);
    reset_in = 1'b1;
    @(negedge reg_clk);
    chk("rst_busdata", 128'(busdata_to_cpu), 128'h0);
    chk("rst_read_valid", 128'(read_valid), 128'h0);
    chk("rst_pad_oe", 128'(pad_oe), 128'h0);
    chk("rst_pad_out", 128'(pad_out), 128'h0);
    chk("rst_irq", 128'(irq), 128'h0);
    @(negedge reg_clk);
    reset_in = 1'b0;
    idle(6);
    chk("post_rst_irq", 128'(irq), 128'h0);
    rd(16'h1600, 32'h0, "stat_after_reset");
    rd(16'h1800, 32'h0, "len_after_reset");
    drain();
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
